decode_pipe_stage: RTL and testbench
====================================

Name: decode_pipe_stage

Overview:
Parametrised successor to the single-register decode step. It takes raw 32-bit RV32 instruction words over a valid/ready handshake, classifies each into group/specifier, and extracts rs1/rs2/rd/funct3/funct7. It assembles the full immediate, extends it to XLEN, and buffers results in a DEPTH-entry output queue with back-pressure and flush. It sits between fetch and the issue/register-read stage.

Parameters:
XLEN, 32, width of extended immediate (32 or 64).
DEPTH, 2, output queue entries (power of two, >=2).
CNT_W, 32, width of decoded-instruction counter.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  instruction word valid.
in_instr  in  32  raw instruction.
in_ready  out  1  stage can accept (queue not full).
flush  in  1  synchronous flush of queue.
out_valid  out  1  head entry valid.
out_ready  in  1  consumer accepts head.
out_opcode  out  7  opcode of head.
out_group  out  2  01 R/I, 10 S/B, 11 U/J, 00 illegal.
out_specifier  out  1  R=0/I=1, S=0/B=1, U=0/J=1.
out_funct3  out  3  bits[14:12].
out_funct7  out  7  bits[31:25].
out_rs1  out  5  bits[19:15].
out_rs2  out  5  bits[24:20].
out_rd  out  5  bits[11:7]; 0 for S/B.
out_imm  out  XLEN  extended immediate.
out_illegal  out  1  head opcode unrecognised.
decoded_count  out  CNT_W  count of output handshakes.

Behaviour:
- Reset (rst_n low, async): queue empty, out_valid=0, in_ready=1, all out_* fields 0, decoded_count=0.
- Classification: 0110011 R(01,0); 0010011/0000011/1100111 I(01,1); 0100011 S(10,0); 1100011 B(10,1); 0110111/0010111 U(11,0); 1101111 J(11,1); else group 00, illegal=1, imm=0.
- Immediates, sign-extended from bit 31 to XLEN:
  - R = 0.
  - I = instr[31:20].
  - S = {[31:25],[11:7]}.
  - B = {[31],[7],[30:25],[11:8],0}.
  - U = {[31:12],12'b0}, sign-extended when XLEN=64.
  - J = {[31],[19:12],[20],[30:21],0}.
- Decode is combinational on in_instr. The result is written into the queue on push (in_valid & in_ready).
- Latency: instruction accepted at edge N appears with out_valid=1 after edge N when the queue was empty. Outputs are registered, with no combinational path in→out.
- in_ready = !full. It does not look ahead to a same-cycle pop.
- Pop on out_valid & out_ready. Simultaneous push and pop at non-full: occupancy unchanged, order preserved.
- Pointers wrap modulo DEPTH. Occupancy counter width is clog2(DEPTH)+1.
- out_* hold stable while out_valid & !out_ready.
- flush: at the next edge the queue empties and out_valid=0. A push in the same cycle is dropped (flush wins). decoded_count still increments if a pop handshake occurred that cycle.
- decoded_count increments once per pop handshake and wraps at 2^CNT_W.
- Reset mid-operation discards all entries immediately.

Optional Feature:
Macro DECODE_ILLEGAL_TRAP_EN.
- Defined: pushing an illegal instruction sets a sticky trap flag. in_ready is forced 0 until flush or reset clears it. The illegal entry still drains normally with out_illegal=1.
- Undefined: illegal entries flow with out_illegal=1 and never stall input.

Test Plan:
- Push 0xFFF00093 (addi x1,x0,-1), out_ready=1 → next cycle out_valid=1, group 01, spec 1, rd 1, rs1 0, imm 0xFFFFFFFF, decoded_count 1.
- Push 0x123452B7 (lui x5,0x12345) → group 11, spec 0, rd 5, imm 0x12345000. With XLEN=64, push 0x800002B7 → imm 0xFFFFFFFF80000000.
- Push 0x0020A423 (sw x2,8(x1)) then 0xFFDFF06F (jal x0,-4) → S: rs1 1, rs2 2, rd 0, imm 8. J: imm 0xFFFFFFFC. Order preserved.
- DEPTH=2, out_ready=0, push 3 back-to-back → in_ready drops after 2nd accept. 3rd held. Raise out_ready → entries drain in order and the 3rd is accepted.
- Queue holding 2 entries, assert flush with in_valid=1 → next cycle out_valid=0, queue empty, pushed word lost, decoded_count unchanged.
- Push 0x0000007F (illegal) → out_illegal=1, group 00, imm 0. With DECODE_ILLEGAL_TRAP_EN, in_ready stays 0 until flush. Deassert rst_n mid-stream → all outputs 0 asynchronously.

Source files
------------

// File: rtl/decode_pipe_stage.sv
// RV32 decode stage: classifies instruction words, extracts fields and the extended
// immediate, and buffers results in a DEPTH-entry queue. Optional: DECODE_ILLEGAL_TRAP_EN.
module decode_pipe_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_opcode,
  output logic [1:0]       out_group,
  output logic             out_specifier,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] decoded_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [1:0]      group;
    logic            specifier;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and in_ready depends only on registered state.
  entry_t          dec;
  logic [31:0]     imm32;
  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0] decoded_count_q, decoded_count_d;
  logic            full, push, pop;

  always_comb begin
    dec        = '0;
    imm32      = '0;
    dec.opcode = in_instr[6:0];
    dec.funct3 = in_instr[14:12];
    dec.funct7 = in_instr[31:25];
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.rd     = in_instr[11:7];
    case (in_instr[6:0])
      7'b0110011: begin
        dec.group = 2'b01; dec.specifier = 1'b0;
      end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec.group = 2'b01; dec.specifier = 1'b1;
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        dec.group = 2'b10; dec.specifier = 1'b0; dec.rd = '0;
        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec.group = 2'b10; dec.specifier = 1'b1; dec.rd = '0;
        imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.group = 2'b11; dec.specifier = 1'b0;
        imm32 = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.group = 2'b11; dec.specifier = 1'b1;
        imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.imm       = {XLEN{imm32[31]}};
    dec.imm[31:0] = imm32;
  end

  assign full = (cnt_q == (PW+1)'(DEPTH));

`ifdef DECODE_ILLEGAL_TRAP_EN
  // Sticky trap: an accepted illegal word blocks input until flush or reset.
  logic trap_q, trap_d;
  assign in_ready = !full && !trap_q;
  always_comb begin
    trap_d = trap_q;
    if (flush)                    trap_d = 1'b0;
    else if (push && dec.illegal) trap_d = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trap_q <= 1'b0;
    else        trap_q <= trap_d;
  end
`else
  assign in_ready = !full;
`endif

  assign out_valid = (cnt_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    mem_d           = mem_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    cnt_d           = cnt_q;
    decoded_count_d = decoded_count_q + (pop ? CNT_W'(1) : CNT_W'(0));
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + (PW+1)'(1);
        2'b01:   cnt_d = cnt_q - (PW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      cnt_q           <= '0;
      decoded_count_q <= '0;
    end else begin
      mem_q           <= mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      cnt_q           <= cnt_d;
      decoded_count_q <= decoded_count_d;
    end
  end

  assign out_opcode    = mem_q[rd_ptr_q].opcode;
  assign out_group     = mem_q[rd_ptr_q].group;
  assign out_specifier = mem_q[rd_ptr_q].specifier;
  assign out_funct3    = mem_q[rd_ptr_q].funct3;
  assign out_funct7    = mem_q[rd_ptr_q].funct7;
  assign out_rs1       = mem_q[rd_ptr_q].rs1;
  assign out_rs2       = mem_q[rd_ptr_q].rs2;
  assign out_rd        = mem_q[rd_ptr_q].rd;
  assign out_imm       = mem_q[rd_ptr_q].imm;
  assign out_illegal   = mem_q[rd_ptr_q].illegal;
  assign decoded_count = decoded_count_q;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Bench for decode_pipe_stage: directed scenarios plus randomized traffic against a
// queue-based reference model; a 64-bit-immediate instance shares the same stimulus.
module tb_decode_pipe_stage;
  localparam int DEPTH = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0;

  logic        in_ready, out_valid, out_specifier, out_illegal;
  logic [6:0]  out_opcode, out_funct7;
  logic [1:0]  out_group;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm, decoded_count;

  logic        in_ready64, out_valid64, out_specifier64, out_illegal64;
  logic [6:0]  out_opcode64, out_funct764;
  logic [1:0]  out_group64;
  logic [2:0]  out_funct364;
  logic [4:0]  out_rs164, out_rs264, out_rd64;
  logic [63:0] out_imm64;
  logic [31:0] decoded_count64;

  int errors = 0, checks = 0;

  decode_pipe_stage #(.XLEN(32), .DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_group(out_group), .out_specifier(out_specifier), .out_funct3(out_funct3),
    .out_funct7(out_funct7), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_illegal(out_illegal), .decoded_count(decoded_count));

  decode_pipe_stage #(.XLEN(64), .DEPTH(DEPTH), .CNT_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready64),
    .flush(flush), .out_valid(out_valid64), .out_ready(out_ready), .out_opcode(out_opcode64),
    .out_group(out_group64), .out_specifier(out_specifier64), .out_funct3(out_funct364),
    .out_funct7(out_funct764), .out_rs1(out_rs164), .out_rs2(out_rs264), .out_rd(out_rd64),
    .out_imm(out_imm64), .out_illegal(out_illegal64), .decoded_count(decoded_count64));

  // Clock and reset
  always #5 clk = ~clk;

  // Reference model
  typedef struct packed {
    logic [6:0]  opcode;
    logic [1:0]  group;
    logic        spec;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic        illegal;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_count = '0;
  bit          trap_m = 1'b0;

  function automatic exp_t decode_ref(input logic [31:0] instr);
    exp_t   e;
    longint x;
    x = longint'($signed(instr));
    e = '0;
    e.opcode = instr[6:0];   e.f3 = instr[14:12]; e.f7 = instr[31:25];
    e.rs1 = instr[19:15];    e.rs2 = instr[24:20]; e.rd = instr[11:7];
    case (instr[6:0])
      7'h33: begin e.group = 2'd1; e.spec = 1'b0; e.imm = '0; end
      7'h13, 7'h03, 7'h67: begin e.group = 2'd1; e.spec = 1'b1; e.imm = x >>> 20; end
      7'h23: begin
        e.group = 2'd2; e.spec = 1'b0; e.rd = '0;
        e.imm = ((x >>> 25) << 5) | longint'(instr[11:7]);
      end
      7'h63: begin
        e.group = 2'd2; e.spec = 1'b1; e.rd = '0;
        e.imm = ((x >>> 31) << 12) | (longint'(instr[7]) << 11) |
                (longint'(instr[30:25]) << 5) | (longint'(instr[11:8]) << 1);
      end
      7'h37, 7'h17: begin e.group = 2'd3; e.spec = 1'b0; e.imm = (x >>> 12) << 12; end
      7'h6F: begin
        e.group = 2'd3; e.spec = 1'b1;
        e.imm = ((x >>> 31) << 20) | (longint'(instr[19:12]) << 12) |
                (longint'(instr[20]) << 11) | (longint'(instr[30:21]) << 1);
      end
      default: begin e.group = 2'd0; e.spec = 1'b0; e.imm = '0; e.illegal = 1'b1; end
    endcase
    return e;
  endfunction

  // Driver: one clock edge, model follows the handshakes that edge performs.
  task automatic advance();
    bit push, pop;
    push = in_valid && (exp_q.size() < DEPTH) && !trap_m;
    pop  = out_ready && (exp_q.size() > 0);
    @(posedge clk); #1;
    if (pop) exp_count++;
    if (flush) begin
      exp_q.delete();
      trap_m = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        exp_q.push_back(decode_ref(in_instr));
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (exp_q[$].illegal) trap_m = 1'b1;
`endif
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if ({out_opcode, out_group, out_rd, out_imm, out_illegal} !== '0) begin errors++; $display("FAIL reset_fields got=%h exp=0", {out_opcode, out_group, out_rd, out_imm, out_illegal}); end
    checks++; if (decoded_count !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", decoded_count); end
    checks++; if (out_imm64 !== 64'd0) begin errors++; $display("FAIL reset_imm64 got=%h exp=0", out_imm64); end
  endtask

  task automatic test_addi();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFFF00093;
    advance();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got=%0b exp=1", out_valid); end
    checks++; if ({out_group, out_specifier, out_rd, out_rs1} !== {2'b01, 1'b1, 5'd1, 5'd0}) begin errors++; $display("FAIL addi_fields got=%h exp=%h", {out_group, out_specifier, out_rd, out_rs1}, {2'b01, 1'b1, 5'd1, 5'd0}); end
    checks++; if (out_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm got=%h exp=ffffffff", out_imm); end
    checks++; if (out_imm64 !== 64'hFFFFFFFF_FFFFFFFF) begin errors++; $display("FAIL addi_imm64 got=%h exp=ffffffffffffffff", out_imm64); end
    advance();
    checks++; if (decoded_count !== 32'd1) begin errors++; $display("FAIL addi_count got=%0d exp=1", decoded_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drained got=%0b exp=0", out_valid); end
  endtask

  task automatic test_lui();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h123452B7;
    advance();
    in_valid = 1'b0;
    checks++; if ({out_group, out_specifier, out_rd} !== {2'b11, 1'b0, 5'd5}) begin errors++; $display("FAIL lui_fields got=%h exp=%h", {out_group, out_specifier, out_rd}, {2'b11, 1'b0, 5'd5}); end
    checks++; if (out_imm !== 32'h12345000) begin errors++; $display("FAIL lui_imm got=%h exp=12345000", out_imm); end
    advance();
    in_valid = 1'b1; in_instr = 32'h800002B7;
    advance();
    in_valid = 1'b0;
    checks++; if (out_imm64 !== 64'hFFFFFFFF_80000000) begin errors++; $display("FAIL lui_imm64 got=%h exp=ffffffff80000000", out_imm64); end
    checks++; if (out_imm !== 32'h80000000) begin errors++; $display("FAIL lui_imm32 got=%h exp=80000000", out_imm); end
    advance();
    checks++; if (decoded_count !== 32'd3) begin errors++; $display("FAIL lui_count got=%0d exp=3", decoded_count); end
  endtask

  task automatic test_store_jal();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0020A423;
    advance();
    in_instr = 32'hFFDFF06F;
    advance();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sj_full got=%0b exp=0", in_ready); end
    checks++; if ({out_group, out_specifier, out_rs1, out_rs2, out_rd} !== {2'b10, 1'b0, 5'd1, 5'd2, 5'd0}) begin errors++; $display("FAIL sw_fields got=%h exp=%h", {out_group, out_specifier, out_rs1, out_rs2, out_rd}, {2'b10, 1'b0, 5'd1, 5'd2, 5'd0}); end
    checks++; if (out_imm !== 32'd8) begin errors++; $display("FAIL sw_imm got=%h exp=8", out_imm); end
    out_ready = 1'b1;
    advance();
    checks++; if ({out_group, out_specifier, out_rd} !== {2'b11, 1'b1, 5'd0}) begin errors++; $display("FAIL jal_fields got=%h exp=%h", {out_group, out_specifier, out_rd}, {2'b11, 1'b1, 5'd0}); end
    checks++; if (out_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL jal_imm got=%h exp=fffffffc", out_imm); end
    advance();
    checks++; if (out_valid !== 1'b0 || decoded_count !== 32'd5) begin errors++; $display("FAIL sj_drain got=%0b/%0d exp=0/5", out_valid, decoded_count); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100113;
    advance();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got=%0b exp=1", in_ready); end
    in_instr = 32'h00200193;
    advance();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready2 got=%0b exp=0", in_ready); end
    in_instr = 32'h00300213;
    advance();
    checks++; if (in_ready !== 1'b0 || out_rd !== 5'd2 || out_imm !== 32'd1) begin errors++; $display("FAIL b2b_hold got=%0b/%0d/%h exp=0/2/1", in_ready, out_rd, out_imm); end
    out_ready = 1'b1;
    advance();
    checks++; if (out_rd !== 5'd3 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_pop1 got=%0d/%0b exp=3/1", out_rd, in_ready); end
    advance();
    in_valid = 1'b0;
    checks++; if (out_rd !== 5'd4 || out_imm !== 32'd3) begin errors++; $display("FAIL b2b_third got=%0d/%h exp=4/3", out_rd, out_imm); end
    advance();
    checks++; if (out_valid !== 1'b0 || decoded_count !== 32'd8) begin errors++; $display("FAIL b2b_drain got=%0b/%0d exp=0/8", out_valid, decoded_count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100113;
    advance();
    in_instr = 32'h00200193;
    advance();
    in_instr = 32'h00300213; flush = 1'b1;
    advance();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_empty got=%0b/%0b exp=0/1", out_valid, in_ready); end
    checks++; if (decoded_count !== 32'd8) begin errors++; $display("FAIL flush_count got=%0d exp=8", decoded_count); end
    advance();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_lost got=%0b exp=0", out_valid); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0000007F;
    advance();
    in_valid = 1'b0;
    checks++; if ({out_valid, out_illegal, out_group, out_imm} !== {1'b1, 1'b1, 2'b00, 32'd0}) begin errors++; $display("FAIL ill_fields got=%h exp=%h", {out_valid, out_illegal, out_group, out_imm}, {1'b1, 1'b1, 2'b00, 32'd0}); end
`ifdef DECODE_ILLEGAL_TRAP_EN
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL trap_ready got=%0b exp=0", in_ready); end
    in_valid = 1'b1; in_instr = 32'h00100113;
    advance();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL trap_sticky got=%0b exp=0", in_ready); end
    flush = 1'b1;
    advance();
    flush = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL trap_clear got=%0b/%0b exp=1/0", in_ready, out_valid); end
`else
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ill_ready got=%0b exp=1", in_ready); end
    out_ready = 1'b1;
    advance();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ill_drain got=%0b exp=0", out_valid); end
`endif
    checks++; if (decoded_count !== exp_count) begin errors++; $display("FAIL ill_count got=%0d exp=%0d", decoded_count, exp_count); end
  endtask

  task automatic test_random();
    logic [6:0] ops [10];
    logic [31:0] r;
    exp_t h;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      r[6:0] = ops[$urandom_range(0, 9)];
      in_instr  = r;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      checks++; if (in_ready !== ((exp_q.size() < DEPTH) && !trap_m) || in_ready64 !== in_ready) begin errors++; $display("FAIL rnd_in_ready n=%0d got=%0b/%0b exp=%0b", n, in_ready, in_ready64, (exp_q.size() < DEPTH) && !trap_m); end
      checks++; if (out_valid !== (exp_q.size() > 0) || out_valid64 !== out_valid) begin errors++; $display("FAIL rnd_out_valid n=%0d got=%0b/%0b exp=%0b", n, out_valid, out_valid64, exp_q.size() > 0); end
      if (exp_q.size() > 0) begin
        h = exp_q[0];
        checks++; if ({out_opcode, out_group, out_specifier, out_funct3, out_funct7, out_rs1, out_rs2, out_rd, out_imm, out_illegal} !== {h.opcode, h.group, h.spec, h.f3, h.f7, h.rs1, h.rs2, h.rd, h.imm[31:0], h.illegal}) begin errors++; $display("FAIL rnd_head32 n=%0d got=%h exp=%h", n, {out_opcode, out_group, out_specifier, out_funct3, out_funct7, out_rs1, out_rs2, out_rd, out_imm, out_illegal}, {h.opcode, h.group, h.spec, h.f3, h.f7, h.rs1, h.rs2, h.rd, h.imm[31:0], h.illegal}); end
        checks++; if ({out_opcode64, out_group64, out_specifier64, out_funct364, out_funct764, out_rs164, out_rs264, out_rd64, out_imm64, out_illegal64} !== h) begin errors++; $display("FAIL rnd_head64 n=%0d got=%h exp=%h", n, {out_opcode64, out_group64, out_specifier64, out_funct364, out_funct764, out_rs164, out_rs264, out_rd64, out_imm64, out_illegal64}, h); end
      end
      advance();
      checks++; if (decoded_count !== exp_count || decoded_count64 !== exp_count) begin errors++; $display("FAIL rnd_count n=%0d got=%0d/%0d exp=%0d", n, decoded_count, decoded_count64, exp_count); end
    end
    in_valid = 1'b0; flush = 1'b1;
    advance();
    flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00093;
    advance();
    in_instr = 32'h123452B7;
    advance();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre got=%0b exp=1", out_valid); end
    rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rmid_flags got=%0b/%0b exp=0/1", out_valid, in_ready); end
    checks++; if ({out_opcode, out_group, out_specifier, out_rd, out_rs1, out_imm, out_illegal} !== '0 || out_imm64 !== 64'd0) begin errors++; $display("FAIL rmid_fields got=%h exp=0", {out_opcode, out_group, out_specifier, out_rd, out_rs1, out_imm, out_illegal}); end
    checks++; if (decoded_count !== 32'd0) begin errors++; $display("FAIL rmid_count got=%0d exp=0", decoded_count); end
    exp_q.delete(); exp_count = '0; trap_m = 1'b0;
    #1 rst_n = 1'b1;
    advance();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_after got=%0b exp=0", out_valid); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    advance();
    test_addi();
    test_lui();
    test_store_jal();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
